cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of execution-unit requesters sharing the CDB (legal 2..4).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ena  input  1  global stall; low = hold all state, accept nothing.
REQ-005 in_flush  input  1  misbranch flush from ROB commit.
REQ-006 in_req_valid  input  NUM_REQ  per-requester result valid.
REQ-007 out_req_ready  output  NUM_REQ  per-requester slot can accept this cycle.
REQ-008 in_req_tag  input  NUM_REQ*ROB_W  ROB tag per requester; ZERO_ROB = no destination.
REQ-009 in_req_value  input  NUM_REQ*DATA_W  result value per requester.
REQ-010 in_req_isjump, in_req_isload  input  NUM_REQ each  branch-taken flag, load flag.
REQ-011 in_req_jump_addr  input  NUM_REQ*DATA_W  resolved branch/JALR target.
REQ-012 out_cdb_rob_tag  output  ROB_W  broadcast tag; ZERO_ROB = bus idle.
REQ-013 out_cdb_value, out_cdb_jump_addr  output  DATA_W each  broadcast payload.
REQ-014 out_cdb_isjump, out_cdb_isload  output  1 each  broadcast flags.
REQ-015 out_busy  output  1  any slot occupied.

Function
REQ-016 Each requester owns one holding slot (valid + tag/value/isjump/isload/jump_addr); handshake completes when in_req_valid[i] & out_req_ready[i] at posedge with ena high.
REQ-017 out_req_ready[i] = ena & !in_flush & (!slot_valid[i] | grant[i]); combinational from slot state, pointer, ena, flush only (no path from in_req_valid).
REQ-018 Accepted request with tag == ZERO_ROB is dropped: slot stays empty, nothing broadcast.
REQ-019 Each cycle at most one occupied slot is granted; grant[i] combinational from slot_valid and rr pointer.
REQ-020 Granted slot drives CDB outputs, all registered at posedge; slot freed same edge; same-edge refill allowed (back-to-back throughput 1/cycle per requester).
REQ-021 Latency: result accepted at edge N appears on outputs after edge N+1 at earliest.
REQ-022 No slot occupied: out_cdb_rob_tag <= ZERO_ROB, other outputs <= zero.
REQ-023 Round-robin: pointer advances to (granted index + 1) mod NUM_REQ after each grant; unchanged when idle; search starts at pointer, wraps NUM_REQ-1 -> 0.
REQ-024 in_flush high with ena: all slots cleared, outputs <= ZERO_ROB/zero, pointer <= 0, inputs that cycle discarded; flush wins over grant and accept.
REQ-025 ena low: slots, pointer and all outputs hold previous values; flush ignored.
REQ-026 out_busy = OR of slot_valid (combinational).

Reset
REQ-027 rst asserted (any time, mid-transfer included): slots invalid, pointer 0, out_cdb_rob_tag = ZERO_ROB, all other outputs 0, immediately without clk.
REQ-028 First acceptance possible at first posedge after rst deasserts.

Configuration
REQ-029 Macro CDB_ROUND_ROBIN_EN defined: arbitration per REQ-023.
REQ-030 Macro CDB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; pointer register absent; all other behaviour identical.

Structure
REQ-031 ROB_W, DATA_W, ZERO_ROB, ZERO_DATA and requester index constants (REQ_ALU=0, REQ_BRANCH=1, REQ_LS=2) come from the shared constants package.
REQ-032 One sub-module cdb_rr_pick: combinational picker (valid vector, pointer -> one-hot grant, index).

Verification
REQ-033 Single: req0 valid tag=5 value=0x1234 -> tag 5 value 0x1234 two edges later, bus idle (ZERO_ROB) after.
REQ-034 Contention: req0,1,2 valid same cycle tags 1,2,3 -> broadcasts 1,2,3 on consecutive cycles (RR); fixed-priority build: same order, then req0 re-request tag 4 preempts pending ones.
REQ-035 Fairness: req0 continuously valid, req2 valid tag 7 -> tag 7 broadcast within NUM_REQ cycles (RR build).
REQ-036 Flush: slots 1,2 full, in_flush pulse -> next output ZERO_ROB, out_busy 0, neither tag ever broadcast.
REQ-037 Stall: ena low 3 cycles with tag 6 pending -> outputs frozen, ready 0; ena high -> tag 6 broadcast next edge.
REQ-038 Reset mid-op: rst asserted between edges with slots full -> outputs zero immediately; zero-tag request (tag 0, valid) -> accepted, never broadcast.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared constants and types for the common data bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [ROB_W-1:0]  ZERO_ROB  = '0;
  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  // Requester index assignment on the CDB
  localparam int REQ_ALU    = 0;
  localparam int REQ_BRANCH = 1;
  localparam int REQ_LS     = 2;

  // One buffered result, as held in a slot and as broadcast on the bus
  typedef struct packed {
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic              isjump;
    logic              isload;
    logic [DATA_W-1:0] jump_addr;
  } cdb_entry_t;

  localparam cdb_entry_t CDB_IDLE = '{
    tag:       ZERO_ROB,
    value:     ZERO_DATA,
    isjump:    1'b0,
    isload:    1'b0,
    jump_addr: ZERO_DATA
  };

  // Width of a requester index; at least one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Requester handshake, control and CDB broadcast signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic                      ena;
  logic                      in_flush;
  logic [NUM_REQ-1:0]        in_req_valid;
  logic [NUM_REQ-1:0]        out_req_ready;
  logic [NUM_REQ*ROB_W-1:0]  in_req_tag;
  logic [NUM_REQ*DATA_W-1:0] in_req_value;
  logic [NUM_REQ-1:0]        in_req_isjump;
  logic [NUM_REQ-1:0]        in_req_isload;
  logic [NUM_REQ*DATA_W-1:0] in_req_jump_addr;
  logic [ROB_W-1:0]          out_cdb_rob_tag;
  logic [DATA_W-1:0]         out_cdb_value;
  logic [DATA_W-1:0]         out_cdb_jump_addr;
  logic                      out_cdb_isjump;
  logic                      out_cdb_isload;
  logic                      out_busy;

  // Execution units and pipeline control side
  modport master (
    output ena, in_flush, in_req_valid, in_req_tag, in_req_value,
           in_req_isjump, in_req_isload, in_req_jump_addr,
    input  out_req_ready, out_cdb_rob_tag, out_cdb_value, out_cdb_jump_addr,
           out_cdb_isjump, out_cdb_isload, out_busy
  );

  // Arbiter side
  modport slave (
    input  ena, in_flush, in_req_valid, in_req_tag, in_req_value,
           in_req_isjump, in_req_isload, in_req_jump_addr,
    output out_req_ready, out_cdb_rob_tag, out_cdb_value, out_cdb_jump_addr,
           out_cdb_isjump, out_cdb_isload, out_busy
  );

endinterface
`default_nettype wire

// File: rtl/cdb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_rr_pick
//  Description : Combinational picker. Searches the valid vector starting at
//                ptr, wrapping NUM_REQ-1 -> 0, and returns the first hit as a
//                one-hot grant plus its binary index.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] k;

  // First valid entry at or after ptr, in circular order
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    sum   = '0;
    k     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      k = sum[IDX_W-1:0];
      if (!any && valid[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        index    = k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common data bus arbiter. Each requester owns a one-entry
//                holding slot; one occupied slot per cycle is granted and its
//                contents are broadcast on registered CDB outputs.
//                Build option CDB_ROUND_ROBIN_EN: defined selects round-robin
//                arbitration, undefined selects fixed priority (index 0 wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  cdb_entry_t         in_entry [NUM_REQ];
  cdb_entry_t         slot     [NUM_REQ];
  logic [NUM_REQ-1:0] slot_valid;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] accept;
  logic               advance;
  cdb_entry_t         cdb_q;

  // Unpack the flat per-requester input buses into entries
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign in_entry[gi] = '{
      tag:       bus.in_req_tag[gi*ROB_W +: ROB_W],
      value:     bus.in_req_value[gi*DATA_W +: DATA_W],
      isjump:    bus.in_req_isjump[gi],
      isload:    bus.in_req_isload[gi],
      jump_addr: bus.in_req_jump_addr[gi*DATA_W +: DATA_W]
    };
  end

  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (slot_valid),
    .ptr   (pick_ptr),
    .grant (grant),
    .index (grant_idx),
    .any   (grant_any)
  );

  // A slot can take a new result when empty or when it is being drained now
  assign ready   = {NUM_REQ{bus.ena & ~bus.in_flush}} & (~slot_valid | grant);
  assign accept  = bus.in_req_valid & ready;
  assign advance = bus.ena & ~bus.in_flush & grant_any;

`ifdef CDB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  // Round-robin pointer moves one past the winner; flush returns it to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (bus.ena) begin
      if (bus.in_flush) begin
        rr_ptr <= '0;
      end else if (advance) begin
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  assign pick_ptr = rr_ptr;
`else
  assign pick_ptr = '0;
`endif

  // Slot fill / drain; a zero-tag result is accepted but never stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot[i] <= CDB_IDLE;
      end
    end else if (bus.ena) begin
      if (bus.in_flush) begin
        slot_valid <= '0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (accept[i]) begin
            slot_valid[i] <= (in_entry[i].tag != ZERO_ROB);
            slot[i]       <= in_entry[i];
          end else if (grant[i]) begin
            slot_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Registered broadcast of the granted slot, idle pattern otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_q <= CDB_IDLE;
    end else if (bus.ena) begin
      if (advance) begin
        cdb_q <= slot[grant_idx];
      end else begin
        cdb_q <= CDB_IDLE;
      end
    end
  end

  assign bus.out_req_ready     = ready;
  assign bus.out_busy          = |slot_valid;
  assign bus.out_cdb_rob_tag   = cdb_q.tag;
  assign bus.out_cdb_value     = cdb_q.value;
  assign bus.out_cdb_isjump    = cdb_q.isjump;
  assign bus.out_cdb_isload    = cdb_q.isload;
  assign bus.out_cdb_jump_addr = cdb_q.jump_addr;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter: directed scenarios plus
//                randomized traffic against a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cdb_arbiter_if #(.NUM_REQ(N)) bus ();

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus
  logic              ena_s, flush_s;
  logic [N-1:0]      iv, ij, il;
  logic [ROB_W-1:0]  itag [N];
  logic [DATA_W-1:0] ival [N];
  logic [DATA_W-1:0] ija  [N];

  // Reference model: per-requester pending result, arbitration start point
  bit                m_valid [N];
  logic [ROB_W-1:0]  m_tag   [N];
  logic [DATA_W-1:0] m_val   [N];
  logic [DATA_W-1:0] m_ja    [N];
  bit                m_j     [N];
  bit                m_l     [N];
  int                m_ptr;
  bit                m_any;
  int                m_g;
  logic [N-1:0]      m_ready;
  logic [ROB_W-1:0]  o_tag;
  logic [DATA_W-1:0] o_val, o_ja;
  bit                o_j, o_l;

  bit seen [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_ptr = 0;
    o_tag = '0; o_val = '0; o_ja = '0; o_j = 0; o_l = 0;
  endtask

  task automatic model_comb();
    int start;
`ifdef CDB_ROUND_ROBIN_EN
    start = m_ptr;
`else
    start = 0;
`endif
    m_any = 0;
    m_g   = 0;
    for (int off = 0; off < N; off++) begin
      int k;
      k = (start + off) % N;
      if (!m_any && m_valid[k]) begin
        m_any = 1;
        m_g   = k;
      end
    end
    for (int i = 0; i < N; i++)
      m_ready[i] = ena_s && !flush_s && (!m_valid[i] || (m_any && m_g == i));
  endtask

  task automatic model_edge();
    if (!ena_s) return;
    if (flush_s) begin
      model_reset();
      return;
    end
    if (m_any) begin
      o_tag = m_tag[m_g]; o_val = m_val[m_g]; o_ja = m_ja[m_g];
      o_j = m_j[m_g]; o_l = m_l[m_g];
      m_valid[m_g] = 0;
      m_ptr = (m_g + 1) % N;
    end else begin
      o_tag = '0; o_val = '0; o_ja = '0; o_j = 0; o_l = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (iv[i] && m_ready[i]) begin
        m_valid[i] = (itag[i] != 0);
        m_tag[i] = itag[i]; m_val[i] = ival[i]; m_ja[i] = ija[i];
        m_j[i] = ij[i]; m_l[i] = il[i];
      end
    end
  endtask

  task automatic drive();
    bus.ena          = ena_s;
    bus.in_flush     = flush_s;
    bus.in_req_valid = iv;
    bus.in_req_isjump = ij;
    bus.in_req_isload = il;
    for (int i = 0; i < N; i++) begin
      bus.in_req_tag[i*ROB_W +: ROB_W]         = itag[i];
      bus.in_req_value[i*DATA_W +: DATA_W]     = ival[i];
      bus.in_req_jump_addr[i*DATA_W +: DATA_W] = ija[i];
    end
  endtask

  // One clock: drive, check combinational outputs, clock, check registered outputs
  task automatic step();
    drive();
    #1;
    model_comb();
    check("ready", bus.out_req_ready, m_ready);
    check("busy", bus.out_busy, (m_valid[0] || m_valid[1] || m_valid[2]));
    @(posedge clk);
    model_edge();
    #1;
    check("cdb_tag", bus.out_cdb_rob_tag, o_tag);
    check("cdb_value", bus.out_cdb_value, o_val);
    check("cdb_jaddr", bus.out_cdb_jump_addr, o_ja);
    check("cdb_isjump", bus.out_cdb_isjump, o_j);
    check("cdb_isload", bus.out_cdb_isload, o_l);
    if (bus.out_cdb_rob_tag != '0) seen[bus.out_cdb_rob_tag] = 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ena_s = 1; flush_s = 0; iv = '0; ij = '0; il = '0;
    for (int i = 0; i < N; i++) begin
      itag[i] = '0; ival[i] = '0; ija[i] = '0;
    end
  endtask

  task automatic flush_clean();
    idle_inputs();
    flush_s = 1;
    step();
    flush_s = 0;
    for (int t = 0; t < 32; t++) seen[t] = 0;
  endtask

  // Asynchronous reset between clock edges
  task automatic reset_mid();
    #1 rst = 1'b1;
    #1;
    check("rst_tag", bus.out_cdb_rob_tag, 0);
    check("rst_value", bus.out_cdb_value, 0);
    check("rst_busy", bus.out_busy, 0);
    rst = 1'b0;
    model_reset();
  endtask

  int exp_order [4];
  bit found7;

  initial begin
    idle_inputs();
    drive();
    #3;
    check("reset_tag", bus.out_cdb_rob_tag, 0);
    check("reset_busy", bus.out_busy, 0);
    check("reset_jaddr", bus.out_cdb_jump_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single request, two-edge latency, idle afterwards
    flush_clean();
    iv = 3'b001; itag[0] = 5; ival[0] = 32'h1234;
    step();
    idle_inputs();
    step();
    check("single_tag", bus.out_cdb_rob_tag, 5);
    check("single_value", bus.out_cdb_value, 32'h1234);
    step();
    check("single_idle", bus.out_cdb_rob_tag, 0);

    // Contention with a re-request from requester 0
`ifdef CDB_ROUND_ROBIN_EN
    exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 3; exp_order[3] = 4;
`else
    exp_order[0] = 1; exp_order[1] = 4; exp_order[2] = 2; exp_order[3] = 3;
`endif
    flush_clean();
    iv = 3'b111; itag[0] = 1; itag[1] = 2; itag[2] = 3;
    step();
    idle_inputs();
    iv = 3'b001; itag[0] = 4;
    step();
    check("contend_0", bus.out_cdb_rob_tag, exp_order[0]);
    idle_inputs();
    for (int s = 1; s < 4; s++) begin
      step();
      check("contend_n", bus.out_cdb_rob_tag, exp_order[s]);
    end

    // Fairness: requester 0 always busy, requester 2 must still get through
    flush_clean();
    iv = 3'b101; itag[0] = 9; itag[2] = 7;
    step();
    found7 = 0;
    itag[2] = 0; iv = 3'b001;
    for (int s = 0; s < N; s++) begin
      itag[0] = ROB_W'(16 + s);
      step();
      if (bus.out_cdb_rob_tag == 7) found7 = 1;
    end
`ifdef CDB_ROUND_ROBIN_EN
    check("fair_tag7", found7, 1);
`endif

    // Flush discards pending slots
    flush_clean();
    iv = 3'b110; itag[1] = 10; itag[2] = 11;
    step();
    idle_inputs();
    flush_s = 1;
    step();
    check("flush_tag", bus.out_cdb_rob_tag, 0);
    check("flush_busy", bus.out_busy, 0);
    flush_s = 0;
    step(); step();
    check("flush_seen10", seen[10], 0);
    check("flush_seen11", seen[11], 0);

    // Stall freezes everything
    flush_clean();
    iv = 3'b010; itag[1] = 8;
    step();
    idle_inputs();
    iv = 3'b001; itag[0] = 6;
    step();
    idle_inputs();
    ena_s = 0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("stall_tag", bus.out_cdb_rob_tag, 8);
      check("stall_ready", bus.out_req_ready, 0);
    end
    ena_s = 1;
    step();
    check("stall_release", bus.out_cdb_rob_tag, 6);

    // Reset mid-operation, then a zero-tag request
    flush_clean();
    iv = 3'b111; itag[0] = 12; itag[1] = 13; itag[2] = 14;
    step();
    idle_inputs();
    step();
    reset_mid();
    iv = 3'b001; itag[0] = 0; ival[0] = 32'hdead;
    step();
    check("zero_tag_busy", bus.out_busy, 0);
    idle_inputs();
    step();
    check("zero_tag_idle", bus.out_cdb_rob_tag, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      ena_s   = ($urandom % 6) != 0;
      flush_s = ($urandom % 20) == 0;
      iv = N'($urandom);
      ij = N'($urandom);
      il = N'($urandom);
      for (int i = 0; i < N; i++) begin
        itag[i] = (($urandom % 8) == 0) ? '0 : ROB_W'($urandom_range(1, 31));
        ival[i] = $urandom;
        ija[i]  = $urandom;
      end
      if (($urandom % 60) == 0) reset_mid();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
